// File: rtl/rv32_pkg.sv
// Shared RV32 core constants.
// Default widths and counts for the register file.
package rv32_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;

endpackage

// File: rtl/rf_wr_bypass.sv
// Write-through bypass for one read port.
// Highest-index matching write port wins; r0 never bypasses.
module rf_wr_bypass
  import rv32_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int AW  = 5,
  parameter int NWR = NUM_WR
) (
  input  logic [AW-1:0]           addr,
  input  logic [DW-1:0]           rf_data,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic [NWR-1:0][DW-1:0]  wr_data,
  output logic [DW-1:0]           data,
  output logic                    hit
);

  always_comb begin
    data = rf_data;
    hit  = 1'b0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w] == addr
          && addr != '0) begin
        data = wr_data[w];
        hit  = 1'b1;
      end
    end
    if (addr == '0) data = '0;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with issue scoreboard.
// Tracks destinations reserved by issue until writeback.
module regfile_sb
  import rv32_pkg::*;
#(
  parameter int DATA_W   = rv32_pkg::DATA_W,
  parameter int NUM_REGS = rv32_pkg::NUM_REGS,
  parameter int NUM_RD   = rv32_pkg::NUM_RD,
  parameter int NUM_WR   = rv32_pkg::NUM_WR,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr_i,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]             rd_busy_o,
  input  logic [NUM_WR-1:0]             wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data_i,
  input  logic                          iss_en_i,
  input  logic [AW-1:0]                 iss_rd_i,
  output logic                          iss_ready_o,
  input  logic                          flush_i,
  output logic [NUM_REGS-1:0]           busy_o,
  output logic [AW:0]                   pend_cnt_o
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] busy_n;
  logic [AW:0]         cnt_n;

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en_i[w]) wr_hit[wr_addr_i[w]] = 1'b1;
    wr_hit[0] = 1'b0;
  end

  assign iss_ready_o = iss_en_i && !flush_i && rst_ni
                    && (iss_rd_i == '0 || !busy_o[iss_rd_i]
                        || wr_hit[iss_rd_i]);

  // Issue set beats writeback clear on the same register.
  always_comb begin
    busy_n = flush_i ? '0 : (busy_o & ~wr_hit);
    if (iss_ready_o) busy_n[iss_rd_i] = 1'b1;
    busy_n[0] = 1'b0;
    cnt_n = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_n = cnt_n + (AW+1)'(busy_n[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy_o     <= '0;
      pend_cnt_o <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en_i[w] && wr_addr_i[w] != '0)
          regs[wr_addr_i[w]] <= wr_data_i[w];
      busy_o     <= busy_n;
      pend_cnt_o <= cnt_n;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic hit;

    rf_wr_bypass #(
      .DW  (DATA_W),
      .AW  (AW),
      .NWR (NUM_WR)
    ) u_byp (
      .addr    (rd_addr_i[p]),
      .rf_data (regs[rd_addr_i[p]]),
      .wr_en   (wr_en_i),
      .wr_addr (wr_addr_i),
      .wr_data (wr_data_i),
      .data    (rd_data_o[p]),
      .hit     (hit)
    );

    assign rd_busy_o[p] = busy_o[rd_addr_i[p]] && !hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_regfile_sb;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_busy;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             iss_en;
  logic [4:0]       iss_rd;
  logic             iss_ready;
  logic             flush;
  logic [31:0]      busy;
  logic [5:0]       pend_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_busy_o   (rd_busy),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .iss_en_i    (iss_en),
    .iss_rd_i    (iss_rd),
    .iss_ready_o (iss_ready),
    .flush_i     (flush),
    .busy_o      (busy),
    .pend_cnt_o  (pend_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_en  = 1'b0;
    iss_rd  = '0;
    flush   = 1'b0;
  endtask

  task automatic neg();
    @(negedge clk);
    idle();
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    neg();
    iss_en = 1'b1;
    iss_rd = r;
    edge1();
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    // Activity during reset must be ignored.
    wr_en[0]   = 1'b1;
    wr_addr[0] = 5'd9;
    wr_data[0] = 32'hCAFE;
    iss_en     = 1'b1;
    iss_rd     = 5'd9;
    #1;
    chk("rst_iss_ready", iss_ready, 0);
    edge1();
    edge1();
    neg();
    rst_n = 1'b1;
    #1;
    for (int r = 0; r < 32; r++) begin
      rd_addr[0] = 5'(r);
      #1;
      chk($sformatf("rst_r%0d", r), rd_data[0], 0);
    end
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend_cnt, 0);

    // Issue r5, then writeback with bypass.
    neg();
    iss_en = 1'b1;
    iss_rd = 5'd5;
    #1;
    chk("iss5_ready", iss_ready, 1);
    edge1();
    chk("iss5_busy", busy, 32'h20);
    chk("iss5_pend", pend_cnt, 1);
    neg();
    rd_addr[0] = 5'd5;
    #1;
    chk("r5_rd_busy", rd_busy[0], 1);
    wr_en[0]   = 1'b1;
    wr_addr[0] = 5'd5;
    wr_data[0] = 32'hDEADBEEF;
    #1;
    chk("r5_byp_data", rd_data[0], 32'hDEADBEEF);
    chk("r5_byp_busy", rd_busy[0], 0);
    edge1();
    chk("r5_clr_busy", busy, 0);
    chk("r5_clr_pend", pend_cnt, 0);

    // Two ports write r7; port 1 wins.
    neg();
    wr_en      = 2'b11;
    wr_addr[0] = 5'd7;
    wr_data[0] = 32'h11;
    wr_addr[1] = 5'd7;
    wr_data[1] = 32'h22;
    rd_addr[1] = 5'd7;
    #1;
    chk("r7_byp", rd_data[1], 32'h22);
    edge1();
    neg();
    rd_addr[0] = 5'd7;
    #1;
    chk("r7_rd", rd_data[0], 32'h22);

    // Re-issue to busy r3.
    issue(5'd3);
    neg();
    iss_en = 1'b1;
    iss_rd = 5'd3;
    #1;
    chk("r3_stall", iss_ready, 0);
    wr_en[1]   = 1'b1;
    wr_addr[1] = 5'd3;
    wr_data[1] = 32'h33;
    #1;
    chk("r3_wr_accept", iss_ready, 1);
    edge1();
    chk("r3_busy_kept", busy, 32'h8);
    chk("r3_pend", pend_cnt, 1);
    neg();
    rd_addr[0] = 5'd3;
    #1;
    chk("r3_rd", rd_data[0], 32'h33);

    // Flush with concurrent issue and write.
    issue(5'd1);
    issue(5'd2);
    issue(5'd4);
    chk("pre_flush_busy", busy, 32'h1E);
    chk("pre_flush_pend", pend_cnt, 4);
    neg();
    flush      = 1'b1;
    iss_en     = 1'b1;
    iss_rd     = 5'd6;
    wr_en[1]   = 1'b1;
    wr_addr[1] = 5'd2;
    wr_data[1] = 32'h5;
    #1;
    chk("flush_iss_ready", iss_ready, 0);
    edge1();
    chk("flush_busy", busy, 0);
    chk("flush_pend", pend_cnt, 0);
    neg();
    rd_addr[0] = 5'd2;
    rd_addr[1] = 5'd6;
    #1;
    chk("flush_r2", rd_data[0], 32'h5);
    chk("flush_r6_busy", rd_busy[1], 0);

    // r0 is hardwired.
    neg();
    wr_en[0]   = 1'b1;
    wr_addr[0] = 5'd0;
    wr_data[0] = 32'hFFFFFFFF;
    iss_en     = 1'b1;
    iss_rd     = 5'd0;
    rd_addr[0] = 5'd0;
    #1;
    chk("r0_iss_ready", iss_ready, 1);
    chk("r0_byp", rd_data[0], 0);
    edge1();
    chk("r0_busy", busy, 0);
    neg();
    #1;
    chk("r0_rd", rd_data[0], 0);

    // Reset mid-operation.
    issue(5'd8);
    issue(5'd9);
    chk("pre_rst_busy", busy, 32'h300);
    chk("pre_rst_pend", pend_cnt, 2);
    neg();
    rst_n      = 1'b0;
    wr_en[0]   = 1'b1;
    wr_addr[0] = 5'd7;
    wr_data[0] = 32'h99;
    iss_en     = 1'b1;
    iss_rd     = 5'd12;
    #1;
    chk("mid_rst_ready", iss_ready, 0);
    edge1();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pend", pend_cnt, 0);
    neg();
    rst_n      = 1'b1;
    rd_addr[0] = 5'd7;
    rd_addr[1] = 5'd3;
    #1;
    chk("mid_rst_r7", rd_data[0], 0);
    chk("mid_rst_r3", rd_data[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default rv32_pkg DATA_W (32), meaning register data width.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning architectural register count (power of two, >=2); AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of read ports (>=1).
REQ-004 SHALL have parameter NUM_WR, default 2, meaning number of write ports (>=1).
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  rising-edge clock; rst_ni  in  1  synchronous active-low reset.
REQ-006 SHALL have rd_addr_i  in  NUM_RD x AW  read addresses.
REQ-007 SHALL have rd_data_o  out  NUM_RD x DATA_W  read data, combinational.
REQ-008 SHALL have rd_busy_o  out  NUM_RD  source register has a pending, not-yet-written result.
REQ-009 SHALL have wr_en_i / wr_addr_i / wr_data_i  in  NUM_WR x (1 / AW / DATA_W)  writeback ports.
REQ-010 SHALL have iss_en_i  in  1, and iss_rd_i  in  AW: issue request reserving a destination.
REQ-011 SHALL have iss_ready_o  out  1  issue accepted this cycle.
REQ-012 SHALL have flush_i  in  1  clear all reservations.
REQ-013 SHALL have busy_o  out  NUM_REGS  registered reservation bitmap.
REQ-014 SHALL have pend_cnt_o  out  AW+1  registered count of set busy bits.

Function
REQ-015 Register 0 SHALL read as zero, never be busy, ignore writes; issue to rd 0 SHALL be accepted without reservation.
REQ-016 Writes SHALL commit on the rising edge when wr_en_i is high; on same-address conflict the highest-index write port SHALL win.
REQ-017 A read whose address matches an active write in the same cycle SHALL return that write data (write-through bypass, same priority as REQ-016).
REQ-018 iss_ready_o SHALL be high when iss_en_i is high, flush_i is low, rst_ni is high, and either iss_rd_i is 0, busy[iss_rd_i] is 0, or iss_rd_i is written this cycle.
REQ-019 An accepted issue (iss_en_i & iss_ready_o, rd != 0) SHALL set busy[iss_rd_i] at the next edge.
REQ-020 A write to register r SHALL clear busy[r] at the next edge; if an issue to r is accepted in the same cycle, the set SHALL win.
REQ-021 rd_busy_o[p] SHALL be busy[rd_addr_i[p]] and not (an active write to that address this cycle).
REQ-022 flush_i SHALL clear all busy bits at the next edge. Writes in the same cycle SHALL still commit. Issue in the same cycle SHALL be rejected.
REQ-023 pend_cnt_o SHALL equal the popcount of busy_o at all times and update in the same cycle as busy_o; it SHALL never exceed NUM_REGS-1.
REQ-024 Writes to non-busy registers SHALL be legal and commit normally.

Reset
REQ-025 While rst_ni is low at a rising edge, all registers SHALL become 0, busy_o SHALL become 0 and pend_cnt_o SHALL become 0.
REQ-026 During reset, writes and issues SHALL be ignored and iss_ready_o SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending reservations with no partial commit.

Structure
REQ-028 Shared package rv32_pkg SHALL hold DATA_W; NUM_REGS, NUM_RD and NUM_WR defaults SHALL be defined there as localparams.
REQ-029 The write-priority/bypass mux SHALL be one sub-module, rf_wr_bypass, instantiated once per read port.
REQ-030 The storage array and scoreboard SHALL stay within regfile_sb.

Verification
REQ-031 Reset, then read all registers -> 0; busy_o=0; pend_cnt_o=0.
REQ-032 Issue rd=5 -> busy_o[5]=1, pend_cnt_o=1; read r5 -> rd_busy_o=1; write r5=0xDEADBEEF -> same-cycle read returns 0xDEADBEEF with rd_busy_o=0; next cycle busy_o[5]=0.
REQ-033 Ports 0 and 1 both write r7, with 0x11 and 0x22 -> same-cycle read and later read both return 0x22.
REQ-034 r3 busy, issue rd=3 without a write -> iss_ready_o=0; issue rd=3 with a same-cycle write to r3 -> accepted, and busy_o[3] stays 1.
REQ-035 Issue r1, r2, r4, then flush together with an issue to r6 and a write r2=0x5 -> busy_o=0, pend_cnt_o=0, r6 not busy, r2 reads 0x5.
REQ-036 Write r0=0xFFFF_FFFF and issue rd=0 -> iss_ready_o=1, r0 reads 0, busy_o[0]=0; reset mid-sequence -> all state 0.
